// File: rtl/iter_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock under start/busy/done.
// Define SIGNED_OPS_EN to enable signed MUL/DIV (op[1]); otherwise op[1] is ignored.
module iter_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   // state  | meaning
   // IDLE   | waiting for start
   // RUN    | one multiply/divide iteration per clock, count down from WIDTH
   // DONE_S | result valid, done pulse, back to IDLE next edge
   typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [CW-1:0]    count;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] ph;
   logic [WIDTH-1:0] pl;
   logic [WIDTH-1:0] m;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_OPS_EN
   always_comb begin
      a_neg = op[1] & a[WIDTH-1];
      b_neg = op[1] & b[WIDTH-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end
`else
   logic unused_op1;
   assign unused_op1 = op[1];
   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
      a_mag = a;
      b_mag = b;
   end
`endif

   // single iteration: shift-add for multiply, restoring subtract for divide
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] nph;
   logic [WIDTH-1:0] npl;

   always_comb begin
      mul_sum  = {1'b0, ph} + {1'b0, (pl[0] ? m : {WIDTH{1'b0}})};
      div_sh   = {ph, pl[WIDTH-1]};
      div_diff = div_sh - {1'b0, m};
      if (is_div) begin
         nph = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
         npl = {pl[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         nph = mul_sum[WIDTH:1];
         npl = {mul_sum[0], pl[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      prod = {nph, npl};
`ifdef SIGNED_OPS_EN
      if (is_div) begin
         res_lo = neg_q ? (~npl + 1'b1) : npl;
         res_hi = neg_r ? (~nph + 1'b1) : nph;
      end else begin
         if (neg_q) prod = ~prod + 1'b1;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
`else
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         ph          <= '0;
         pl          <= '0;
         m           <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  is_div      <= op[0];
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  if (op[0] && (b == '0)) begin
                     hi          <= a;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE_S;
                  end else begin
                     ph    <= '0;
                     pl    <= a_mag;
                     m     <= b_mag;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     count <= CW'(WIDTH);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               count <= count - 1'b1;
               ph    <= nph;
               pl    <= npl;
               if (count == CW'(1)) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  done  <= 1'b1;
                  state <= DONE_S;
               end
            end
            DONE_S: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed-vector bench for iter_muldiv_unit: results, latency, handshake, abort and start blocking.
module tb_iter_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   iter_muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // waits for idle, applies start for one edge, then scrambles a/b
   task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   int n;
   int dones;

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset hi/lo", {hi, lo}, 64'd0);
      chk("reset dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk); rst = 1'b0;

      // MULU max*max
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulu busy after accept", 64'(busy), 64'd1);
      wait_done(n);
      chk("mulu latency", 64'(n), 64'd32);
      chk("mulu hi", 64'(hi), 64'hFFFF_FFFE);
      chk("mulu lo", 64'(lo), 64'h0000_0001);
      chk("mulu dbz", 64'(div_by_zero), 64'd0);
      @(posedge clk); #1;
      chk("done single pulse", 64'(done), 64'd0);
      chk("busy falls after done", 64'(busy), 64'd0);

      // DIVU 100/7 then back-to-back start as busy falls
      issue(2'b01, 32'd100, 32'd7);
      wait_done(n);
      chk("divu latency", 64'(n), 64'd32);
      chk("divu 100/7", {hi, lo}, {32'd2, 32'd14});
      chk("divu dbz", 64'(div_by_zero), 64'd0);
      @(posedge clk); #1;
      chk("idle after done", 64'(busy), 64'd0);
      issue(2'b00, 32'd3, 32'd4);
      chk("start accepted as busy falls", 64'(busy), 64'd1);
      wait_done(n);
      chk("mulu 3*4", {hi, lo}, {32'd0, 32'd12});

      // DIVU max/1, full-width quotient
      issue(2'b01, 32'hFFFF_FFFF, 32'd1);
      wait_done(n);
      chk("divu max/1", {hi, lo}, {32'd0, 32'hFFFF_FFFF});

      // divide by zero
      issue(2'b01, 32'h1234, 32'd0);
      wait_done(n);
      chk("div0 latency", 64'(n), 64'd0);
      chk("div0 dbz", 64'(div_by_zero), 64'd1);
      chk("div0 result", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
      issue(2'b01, 32'd9, 32'd3);
      chk("dbz cleared on accept", 64'(div_by_zero), 64'd0);
      chk("hi/lo hold during run", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
      wait_done(n);
      chk("divu 9/3", {hi, lo}, {32'd0, 32'd3});

`ifdef SIGNED_OPS_EN
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      chk("div -7/2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(2'b10, 32'hFFFF_FFFD, 32'd5);
      wait_done(n);
      chk("mul -3*5", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      chk("div overflow", {hi, lo}, {32'd0, 32'h8000_0000});
      issue(2'b11, 32'hFFFF_FFF9, 32'd0);
      wait_done(n);
      chk("signed div0", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
`else
      issue(2'b10, 32'hFFFF_FFFD, 32'd5);
      wait_done(n);
      chk("mul as mulu", {hi, lo}, {32'd4, 32'hFFFF_FFF1});
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      chk("div as divu", {hi, lo}, {32'd1, 32'h7FFF_FFFC});
`endif

      // abort with rst mid-run, start asserted alongside rst
      issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = 2'b00;
      @(posedge clk); #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort hi/lo", {hi, lo}, 64'd0);
      chk("abort done", 64'(done), 64'd0);
      @(negedge clk); rst = 1'b0; start = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("no done after abort", 64'(dones), 64'd0);

      // start held through RUN/DONE with changing operands
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
      dones = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 45; i++) begin
         a = $urandom; b = $urandom; op = 2'b00;
         @(negedge clk);
         if (!busy) start = 1'b0;
         @(posedge clk); #1;
         if (done) dones++;
      end
      start = 1'b0;
      chk("one done per start", 64'(dones), 64'd1);
      chk("held start result", {hi, lo}, {32'd2, 32'd14});

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
